// File: rtl/cap_sense_scanner.sv
// ---------------------------------------------------------------------------
// cap_sense_scanner
//
// Purpose:
//   Scans nine capacitive touch pads that share one charge/discharge drive.
//   Each measurement has three phases:
//     1. The shared drive is held low for DISCHARGE_CYCLES cycles.
//     2. The drive is raised, and a charge counter runs. Each pad records the
//        count at which its synchronized input first reads high.
//     3. All nine results are published together with a one-cycle valid
//        strobe.
//   The scan then repeats with no idle cycles between measurements.
//
// Parameters:
//   DISCHARGE_CYCLES  cycles the drive is held low before each measurement (>= 2)
//   TIMEOUT           maximum charge count, 1..65535
//
// Ports:
//   clock                        system clock; all state changes on its rising edge
//   reset                        synchronous, active-high reset
//   capacitive_sensors_in[8:0]   raw asynchronous pad levels, one bit per channel
//   capacitive_sensors_out       shared charge (1) / discharge (0) drive
//   capacitive_sensor_readings   nine 32-bit lanes; lane i = bits [32i+31:32i]
//                                  [15:0] charge count, [30:16] zero,
//                                  [31] timeout flag
//   readings_valid               one-cycle pulse while a fresh set is shown
// ---------------------------------------------------------------------------
module cap_sense_scanner #(
  parameter int DISCHARGE_CYCLES = 1000,
  parameter int TIMEOUT          = 65535
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [8:0]   capacitive_sensors_in,
  output logic         capacitive_sensors_out,
  output logic [287:0] capacitive_sensor_readings,
  output logic         readings_valid
);

  localparam int              DW          = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [DW-1:0]   DIS_LAST    = DW'(DISCHARGE_CYCLES - 1);
  localparam logic [15:0]     TIMEOUT_VAL = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    DISCHARGE,
    CHARGE,
    UPDATE
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [8:0]     sync_meta;
  logic [8:0]     sync_in;
  logic [DW-1:0]  discharge_timer;
  logic [15:0]    charge_count;
  logic [8:0]     done;
  logic [15:0]    captured [9];

  logic           discharge_last;
  logic           at_timeout;
  logic           all_done_now;
  logic           end_of_charge;
  logic [8:0]     capture_now;
  logic [287:0]   final_readings;

  // Phase decisions and outputs, all derived from the registered state.
  // A channel counts as done in the cycle its synchronized input is seen
  // high, so the last channel completing exactly at TIMEOUT is reported as
  // a real reading rather than a timeout.
  always_comb begin
    next_state             = state;
    capacitive_sensors_out = 1'b0;
    readings_valid         = 1'b0;
    end_of_charge          = 1'b0;
    discharge_last         = (discharge_timer == DIS_LAST);
    at_timeout             = (charge_count == TIMEOUT_VAL);
    all_done_now           = &(done | sync_in);
    capture_now            = (state == CHARGE) ? (sync_in & ~done) : 9'd0;

    case (state)
      DISCHARGE: begin
        if (discharge_last) begin
          next_state = CHARGE;
        end
      end
      CHARGE: begin
        capacitive_sensors_out = 1'b1;
        if (all_done_now || at_timeout) begin
          next_state    = UPDATE;
          end_of_charge = 1'b1;
        end
      end
      UPDATE: begin
        readings_valid = 1'b1;
        next_state     = DISCHARGE;
      end
      default: begin
        next_state = DISCHARGE;
      end
    endcase
  end

  // Final lane values for the measurement that is ending this cycle.
  // A channel that was neither done earlier nor is high now can only be
  // here because the counter hit TIMEOUT, so it takes the counter value
  // (equal to TIMEOUT) and raises its timeout flag.
  always_comb begin
    final_readings = '0;
    for (int i = 0; i < 9; i++) begin
      final_readings[32*i +: 32] = {
        ~done[i] & ~sync_in[i],
        15'd0,
        done[i] ? captured[i] : charge_count
      };
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DISCHARGE;
    end else begin
      state <= next_state;
    end
  end

  // Two-flop synchronizer on the raw pad levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= '0;
      sync_in   <= '0;
    end else begin
      sync_meta <= capacitive_sensors_in;
      sync_in   <= sync_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      discharge_timer <= '0;
    end else if (state == DISCHARGE && !discharge_last) begin
      discharge_timer <= discharge_timer + DW'(1);
    end else begin
      discharge_timer <= '0;
    end
  end

  // Counter is 0 in the first CHARGE cycle. It stops advancing on the exit
  // cycle, so TIMEOUT=65535 never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      charge_count <= '0;
    end else if (state == CHARGE && !end_of_charge) begin
      charge_count <= charge_count + 16'd1;
    end else begin
      charge_count <= '0;
    end
  end

  // Per-channel capture. Once a channel is done it ignores its input until
  // the next measurement.
  always_ff @(posedge clock) begin
    if (reset || state != CHARGE) begin
      done <= '0;
      for (int i = 0; i < 9; i++) begin
        captured[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (capture_now[i]) begin
          captured[i] <= charge_count;
          done[i]     <= 1'b1;
        end
      end
    end
  end

  // All lanes load on one edge, so the set is shown in the UPDATE cycle
  // together with readings_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      capacitive_sensor_readings <= '0;
    end else if (end_of_charge) begin
      capacitive_sensor_readings <= final_readings;
    end
  end

endmodule

// File: tb/tb_cap_sense_scanner.sv
// ---------------------------------------------------------------------------
// tb_cap_sense_scanner
//
// Bench for cap_sense_scanner with DISCHARGE_CYCLES=4 and TIMEOUT=20.
// Each scan has an input plan. The plan gives a 9-bit pad vector for every
// cycle, indexed relative to the first cycle in which the drive is high.
// The reference model derives each lane from a simple rule: the synchronized
// pad seen at charge count j is the raw pad two cycles earlier. The lane
// value is the first such j, or TIMEOUT with the flag set.
// The scan schedule is derived from the same rule.
// ---------------------------------------------------------------------------
module tb_cap_sense_scanner;

  localparam int D     = 4;
  localparam int TO    = 20;
  localparam int NEVER = 1000;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [8:0]   capacitive_sensors_in = '0;
  logic         capacitive_sensors_out;
  logic [287:0] capacitive_sensor_readings;
  logic         readings_valid;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [8:0]   plan [64];
  logic [287:0] held_readings = '0;
  int           d_val [9];

  cap_sense_scanner #(
    .DISCHARGE_CYCLES(D),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .capacitive_sensors_in(capacitive_sensors_in),
    .capacitive_sensors_out(capacitive_sensors_out),
    .capacitive_sensor_readings(capacitive_sensor_readings),
    .readings_valid(readings_valid)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearPlan();
    for (int idx = 0; idx < 64; idx++) begin
      plan[idx] = '0;
    end
  endtask

  // Channel ch goes high d cycles after the drive rises and stays high.
  task automatic planRise(input int ch, input int d);
    for (int r = -D; r < 64 - D; r++) begin
      plan[r + D][ch] = (r >= d);
    end
  endtask

  task automatic modelScan(output logic [287:0] readings_exp, output int last_count);
    bit all_found;
    int max_count;
    int cnt;
    all_found    = 1'b1;
    max_count    = 0;
    readings_exp = '0;
    for (int ch = 0; ch < 9; ch++) begin
      cnt = -1;
      for (int j = 0; j <= TO; j++) begin
        if (cnt < 0 && plan[j - 2 + D][ch]) begin
          cnt = j;
        end
      end
      if (cnt < 0) begin
        readings_exp[32*ch +: 32] = {1'b1, 15'd0, 16'(TO)};
        all_found = 1'b0;
      end else begin
        readings_exp[32*ch +: 32] = {1'b0, 15'd0, 16'(cnt)};
        if (cnt > max_count) begin
          max_count = cnt;
        end
      end
    end
    last_count = all_found ? max_count : TO;
  endtask

  // Runs one scan from its first discharge cycle through the UPDATE cycle.
  // The task is entered #1 after the edge that starts discharge cycle 1.
  // If abort_at matches a relative cycle, reset is raised in that cycle.
  task automatic applyStimulus(input string name, input int abort_at);
    logic [287:0] next_exp;
    int last;
    modelScan(next_exp, last);
    for (int r = -D; r <= last + 1; r++) begin
      capacitive_sensors_in = plan[r + D];
      checkOutput({name, "_drive"}, 288'(capacitive_sensors_out), 288'(r >= 0 && r <= last));
      checkOutput({name, "_valid"}, 288'(readings_valid), 288'(r == last + 1));
      if (r == last + 1) begin
        held_readings = next_exp;
      end
      checkOutput({name, "_readings"}, capacitive_sensor_readings, held_readings);
      if (r == abort_at) begin
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput({name, "_abort_readings"}, capacitive_sensor_readings, '0);
        checkOutput({name, "_abort_drive"}, 288'(capacitive_sensors_out), '0);
        checkOutput({name, "_abort_valid"}, 288'(readings_valid), '0);
        @(posedge clock); #1;
        checkOutput({name, "_abort_hold_drive"}, 288'(capacitive_sensors_out), '0);
        reset = 1'b0;
        held_readings = '0;
        return;
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    bit dup;
    clearPlan();
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_drive", 288'(capacitive_sensors_out), '0);
    checkOutput("reset_valid", 288'(readings_valid), '0);
    checkOutput("reset_readings", capacitive_sensor_readings, '0);
    reset = 1'b0;

    // No pad ever rises: full-length charge, every lane times out.
    clearPlan();
    applyStimulus("all_timeout", NEVER);
    checkOutput("all_timeout_lane0", 288'(capacitive_sensor_readings[31:0]), 288'(32'h80000014));
    checkOutput("all_timeout_lane8", 288'(capacitive_sensor_readings[287:256]), 288'(32'h80000014));

    // Second measurement is cut short by reset during CHARGE.
    clearPlan();
    for (int ch = 0; ch < 9; ch++) planRise(ch, 6 + ch);
    applyStimulus("abort", 3);

    // Early exit once every channel is done.
    clearPlan();
    for (int ch = 0; ch < 9; ch++) planRise(ch, 10);
    planRise(3, 5);
    applyStimulus("early_exit", NEVER);
    checkOutput("early_exit_lane3", 288'(capacitive_sensor_readings[127:96]), 288'(32'h00000007));
    checkOutput("early_exit_lane0", 288'(capacitive_sensor_readings[31:0]), 288'(32'h0000000C));

    // Last channel completes exactly at TIMEOUT.
    clearPlan();
    for (int ch = 1; ch < 9; ch++) planRise(ch, int'($urandom_range(0, 15)));
    planRise(0, 18);
    applyStimulus("done_at_timeout", NEVER);
    checkOutput("done_at_timeout_lane0", 288'(capacitive_sensor_readings[31:0]), 288'(32'h00000014));

    // Short pulse on channel 5, followed by random toggling.
    clearPlan();
    for (int ch = 0; ch < 9; ch++) planRise(ch, int'($urandom_range(0, 17)));
    for (int r = -D; r < 64 - D; r++) begin
      if (r >= 2 && r <= 4) plan[r + D][5] = 1'b1;
      else if (r >= 5) plan[r + D][5] = 1'($urandom_range(0, 1));
      else plan[r + D][5] = 1'b0;
    end
    applyStimulus("pulse_ch5", NEVER);
    checkOutput("pulse_ch5_lane5", 288'(capacitive_sensor_readings[191:160]), 288'(32'h00000004));

    // Three back-to-back scans with distinct rise times. Some rise times
    // are past the timeout; one channel is high before the charge starts.
    for (int s = 0; s < 3; s++) begin
      clearPlan();
      for (int ch = 0; ch < 9; ch++) begin
        do begin
          d_val[ch] = int'($urandom_range(0, 22));
          dup = 1'b0;
          for (int k = 0; k < ch; k++) begin
            if (d_val[k] == d_val[ch]) dup = 1'b1;
          end
        end while (dup);
        planRise(ch, d_val[ch]);
      end
      if (s == 1) planRise(s + 1, -D);
      applyStimulus($sformatf("random_scan%0d", s), NEVER);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
